cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single backing memory/LSU port between the instruction-cache miss path and the data-cache miss/write-back path.
- Sits between the two cache FSMs' memory-request interfaces and the LSU.
- Round-robin arbitration with grant lock: the owner keeps the port until the memory returns ready.
- Includes a watchdog abort and a sticky protocol-error flag.

Parameters:
- ADDR_W, 32, request address width.
- LINE_W, 128, cache-line data width on the read and write paths.
- MAX_WAIT, 255, maximum BUSY cycles without mem_ready_i before abort. Must be ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ic_req_valid_i  in  1  I-cache miss request.
- ic_req_addr_i  in  ADDR_W  I-cache line address.
- ic_rdata_o  out  LINE_W  read line to I-cache.
- ic_ready_o  out  1  I-cache transaction complete.
- dc_req_valid_i  in  1  D-cache request.
- dc_req_addr_i  in  ADDR_W  D-cache line address.
- dc_req_data_i  in  LINE_W  D-cache write-back line.
- dc_req_rw_i  in  1  1 = write, 0 = read.
- dc_rdata_o  out  LINE_W  read line to D-cache.
- dc_ready_o  out  1  D-cache transaction complete.
- mem_valid_o  out  1  request to memory.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  LINE_W  memory write data.
- mem_rw_o  out  1  memory write enable.
- mem_rdata_i  in  LINE_W  memory read data.
- mem_ready_i  in  1  memory response valid.
- owner_o  out  2  00 none, 01 I-cache, 10 D-cache.
- err_o  out  1  sticky: protocol violation or timeout.
- ic_grant_cnt_o  out  32  perf counter (see Optional Feature).
- dc_grant_cnt_o  out  32  perf counter.
- conflict_cnt_o  out  32  perf counter.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State IDLE; owner_o = 00; last_grant = I (so D wins the first conflict); wait counter = 0; err_o = 0; perf counters = 0.
  - All ready/valid outputs 0; mem_addr_o, mem_wdata_o, mem_rw_o = 0.
  - Reset mid-transaction drops mem_valid_o the next cycle. Neither cache receives ready.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Only ic valid → GNT_I. Only dc valid → GNT_D.
  - Both valid → grant the requester that is not last_grant; update last_grant.
  - Neither valid → stay in IDLE.
- Latency:
  - Request sampled in IDLE at edge N; mem_valid_o and the muxed addr/data/rw are driven from cycle N+1 (registered owner, combinational mux).
  - Minimum request-to-ready is 2 cycles plus memory latency.
- GNT_I:
  - mem_addr_o = ic_req_addr_i; mem_rw_o = 0; mem_wdata_o = 0; mem_valid_o = ic_req_valid_i.
- GNT_D:
  - mem_addr_o, mem_wdata_o, mem_rw_o come from the dc_* inputs; mem_valid_o = dc_req_valid_i.
- Response routing:
  - mem_rdata_i goes to the owner's rdata output; the non-owner's rdata output is 0.
  - mem_ready_i is forwarded combinationally to the owner's ready output only.
  - On mem_ready_i in GNT_x → IDLE at that edge. A waiting requester is granted one cycle later (one idle bubble, fixed).
- mem_ready_i while in IDLE: ignored, no ready output asserted, err_o set.
- Owner drops valid before ready (abort): → IDLE next edge, mem_valid_o deasserts combinationally, err_o set. last_grant is unchanged from grant time.
- Watchdog:
  - Counter runs in GNT_x and clears on entering IDLE.
  - When the counter reaches MAX_WAIT with no mem_ready_i → IDLE and err_o set. The owner receives no ready; the cache must retry.
- Simultaneous mem_ready_i and timeout on the same cycle: ready wins, no error.
- err_o is cleared only by rst_i.
- Fairness: under continuous requests from both sides, grants strictly alternate D, I, D, I, ...

Optional Feature:
- Macro: CACHE_MEM_ARBITER_PERF_EN.
- Defined:
  - ic_grant_cnt_o and dc_grant_cnt_o increment on each grant (IDLE→GNT_x).
  - conflict_cnt_o increments when both requests are valid in IDLE.
  - All three wrap at 2^32 and reset to 0.
- Undefined: the three ports remain and are tied to 0; no counter flops are synthesized.

Test Plan:
- dc read only, addr 0x100, memory ready after 3 cycles:
  - mem_valid_o rises at N+1 with mem_addr_o = 0x100, mem_rw_o = 0.
  - dc_ready_o pulses with dc_rdata_o = mem_rdata_i; ic_ready_o stays 0; owner_o returns to 00.
- ic 0x200 and dc write 0x300 (data 0xA5..A5) asserted in the same cycle after reset:
  - D granted first, with mem_rw_o = 1 and mem_wdata_o = 0xA5..A5.
  - After its ready, one idle cycle, then I granted with mem_addr_o = 0x200 and mem_rw_o = 0.
- Both requesters held continuously for 6 transactions: owner sequence D, I, D, I, D, I; conflict_cnt_o = 6 with PERF_EN.
- MAX_WAIT = 4, memory never ready: return to IDLE after 4 BUSY cycles; err_o = 1; no ready pulse; ic grant proceeds afterwards.
- dc valid dropped 2 cycles into GNT_D: mem_valid_o = 0 the same cycle; IDLE next edge; err_o = 1. Then assert rst_i: err_o = 0 and all counters = 0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Round-robin, grant-locked arbiter sharing one memory port between I-cache and D-cache misses.
// Optional perf counters enabled by defining CACHE_MEM_ARBITER_PERF_EN.
module cache_mem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned LINE_W   = 128,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ic_req_valid_i,
   input  logic [ADDR_W-1:0] ic_req_addr_i,
   output logic [LINE_W-1:0] ic_rdata_o,
   output logic              ic_ready_o,
   input  logic              dc_req_valid_i,
   input  logic [ADDR_W-1:0] dc_req_addr_i,
   input  logic [LINE_W-1:0] dc_req_data_i,
   input  logic              dc_req_rw_i,
   output logic [LINE_W-1:0] dc_rdata_o,
   output logic              dc_ready_o,
   output logic              mem_valid_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   output logic              mem_rw_o,
   input  logic [LINE_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic [1:0]        owner_o,
   output logic              err_o,
   output logic [31:0]       ic_grant_cnt_o,
   output logic [31:0]       dc_grant_cnt_o,
   output logic [31:0]       conflict_cnt_o
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   // Encoding doubles as the owner_o value.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StGntI = 2'b01,
      StGntD = 2'b10
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_d;
   logic              w_last_d_nxt;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_err;
   logic              w_err_set;
   logic              w_grant_i;
   logic              w_grant_d;
   logic              w_conflict;
   logic              w_own_valid;
   logic              w_timeout;

   assign w_own_valid = (r_state == StGntI) ? ic_req_valid_i :
                        (r_state == StGntD) ? dc_req_valid_i : 1'b0;
   assign w_timeout   = (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

   always_comb begin
      w_state_nxt  = r_state;
      w_last_d_nxt = r_last_d;
      w_err_set    = 1'b0;
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      w_conflict   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (ic_req_valid_i && dc_req_valid_i) begin
               w_conflict = 1'b1;
               w_grant_i  = r_last_d;
               w_grant_d  = !r_last_d;
            end else begin
               w_grant_i = ic_req_valid_i;
               w_grant_d = dc_req_valid_i;
            end
            if (w_grant_i) begin
               w_state_nxt  = StGntI;
               w_last_d_nxt = 1'b0;
            end else if (w_grant_d) begin
               w_state_nxt  = StGntD;
               w_last_d_nxt = 1'b1;
            end
            // A response with no owner is a protocol violation.
            w_err_set = mem_ready_i;
         end
         StGntI, StGntD: begin
            if (mem_ready_i) begin
               w_state_nxt = StIdle;
            end else if (!w_own_valid || w_timeout) begin
               w_state_nxt = StIdle;
               w_err_set   = 1'b1;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= StIdle;
         r_last_d   <= 1'b0;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_last_d <= w_last_d_nxt;
         r_err    <= r_err | w_err_set;
         if (r_state == StIdle || w_state_nxt == StIdle) begin
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      mem_valid_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_rw_o    = 1'b0;
      ic_rdata_o  = '0;
      dc_rdata_o  = '0;
      ic_ready_o  = 1'b0;
      dc_ready_o  = 1'b0;
      unique case (r_state)
         StGntI: begin
            mem_valid_o = ic_req_valid_i;
            mem_addr_o  = ic_req_addr_i;
            ic_rdata_o  = mem_rdata_i;
            ic_ready_o  = mem_ready_i && !rst_i;
         end
         StGntD: begin
            mem_valid_o = dc_req_valid_i;
            mem_addr_o  = dc_req_addr_i;
            mem_wdata_o = dc_req_data_i;
            mem_rw_o    = dc_req_rw_i;
            dc_rdata_o  = mem_rdata_i;
            dc_ready_o  = mem_ready_i && !rst_i;
         end
         default: ;
      endcase
   end

   assign owner_o = r_state;
   assign err_o   = r_err;

`ifdef CACHE_MEM_ARBITER_PERF_EN
   logic [31:0] r_ic_grant_cnt;
   logic [31:0] r_dc_grant_cnt;
   logic [31:0] r_conflict_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ic_grant_cnt <= '0;
         r_dc_grant_cnt <= '0;
         r_conflict_cnt <= '0;
      end else begin
         if (w_grant_i) r_ic_grant_cnt <= r_ic_grant_cnt + 32'd1;
         if (w_grant_d) r_dc_grant_cnt <= r_dc_grant_cnt + 32'd1;
         if (w_conflict) r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   assign ic_grant_cnt_o = r_ic_grant_cnt;
   assign dc_grant_cnt_o = r_dc_grant_cnt;
   assign conflict_cnt_o = r_conflict_cnt;
`else
   assign ic_grant_cnt_o = 32'd0;
   assign dc_grant_cnt_o = 32'd0;
   assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (MAX_WAIT = 4 instance).
module tb_cache_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 128;
`ifdef CACHE_MEM_ARBITER_PERF_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              ic_req_valid_i;
   logic [ADDR_W-1:0] ic_req_addr_i;
   logic [LINE_W-1:0] ic_rdata_o;
   logic              ic_ready_o;
   logic              dc_req_valid_i;
   logic [ADDR_W-1:0] dc_req_addr_i;
   logic [LINE_W-1:0] dc_req_data_i;
   logic              dc_req_rw_i;
   logic [LINE_W-1:0] dc_rdata_o;
   logic              dc_ready_o;
   logic              mem_valid_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_wdata_o;
   logic              mem_rw_o;
   logic [LINE_W-1:0] mem_rdata_i;
   logic              mem_ready_i;
   logic [1:0]        owner_o;
   logic              err_o;
   logic [31:0]       ic_grant_cnt_o;
   logic [31:0]       dc_grant_cnt_o;
   logic [31:0]       conflict_cnt_o;

   int n_checks = 0;
   int n_fails  = 0;

   cache_mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .LINE_W  (LINE_W),
      .MAX_WAIT(4)
   ) u_dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ic_req_valid_i(ic_req_valid_i),
      .ic_req_addr_i (ic_req_addr_i),
      .ic_rdata_o    (ic_rdata_o),
      .ic_ready_o    (ic_ready_o),
      .dc_req_valid_i(dc_req_valid_i),
      .dc_req_addr_i (dc_req_addr_i),
      .dc_req_data_i (dc_req_data_i),
      .dc_req_rw_i   (dc_req_rw_i),
      .dc_rdata_o    (dc_rdata_o),
      .dc_ready_o    (dc_ready_o),
      .mem_valid_o   (mem_valid_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rw_o      (mem_rw_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_ready_i   (mem_ready_i),
      .owner_o       (owner_o),
      .err_o         (err_o),
      .ic_grant_cnt_o(ic_grant_cnt_o),
      .dc_grant_cnt_o(dc_grant_cnt_o),
      .conflict_cnt_o(conflict_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
   task automatic next_cyc();
      @(negedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i          = 1'b1;
      ic_req_valid_i = 1'b0;
      ic_req_addr_i  = '0;
      dc_req_valid_i = 1'b0;
      dc_req_addr_i  = '0;
      dc_req_data_i  = '0;
      dc_req_rw_i    = 1'b0;
      mem_rdata_i    = '0;
      mem_ready_i    = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
   endtask

   localparam logic [127:0] RdPat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] WrPat = {16{8'hA5}};

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      do_reset();
      check_eq("rst_owner", owner_o, 2'b00);
      check_eq("rst_err", err_o, 1'b0);
      check_eq("rst_mem_valid", mem_valid_o, 1'b0);
      check_eq("rst_cnts", {ic_grant_cnt_o, dc_grant_cnt_o, conflict_cnt_o}, '0);

      // dc read 0x100, memory ready on the third busy cycle
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h100;
      #1;
      check_eq("t1_idle_valid", mem_valid_o, 1'b0);
      next_cyc();
      check_eq("t1_valid", mem_valid_o, 1'b1);
      check_eq("t1_addr", mem_addr_o, 32'h100);
      check_eq("t1_rw", mem_rw_o, 1'b0);
      check_eq("t1_owner", owner_o, 2'b10);
      next_cyc();
      next_cyc();
      mem_rdata_i = RdPat;
      mem_ready_i = 1'b1;
      #1;
      check_eq("t1_dc_ready", dc_ready_o, 1'b1);
      check_eq("t1_dc_rdata", dc_rdata_o, RdPat);
      check_eq("t1_ic_ready", ic_ready_o, 1'b0);
      check_eq("t1_ic_rdata", ic_rdata_o, '0);
      @(negedge clk_i);
      mem_ready_i    = 1'b0;
      dc_req_valid_i = 1'b0;
      #1;
      check_eq("t1_owner_done", owner_o, 2'b00);
      check_eq("t1_err", err_o, 1'b0);

      // simultaneous ic read and dc write: D first, bubble, then I
      do_reset();
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h200;
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h300;
      dc_req_data_i  = WrPat;
      dc_req_rw_i    = 1'b1;
      next_cyc();
      check_eq("t2_owner_d", owner_o, 2'b10);
      check_eq("t2_addr_d", mem_addr_o, 32'h300);
      check_eq("t2_rw_d", mem_rw_o, 1'b1);
      check_eq("t2_wdata_d", mem_wdata_o, WrPat);
      mem_ready_i = 1'b1;
      #1;
      check_eq("t2_dc_ready", dc_ready_o, 1'b1);
      check_eq("t2_ic_ready_low", ic_ready_o, 1'b0);
      @(negedge clk_i);
      mem_ready_i    = 1'b0;
      dc_req_valid_i = 1'b0;
      #1;
      check_eq("t2_bubble_owner", owner_o, 2'b00);
      check_eq("t2_bubble_valid", mem_valid_o, 1'b0);
      next_cyc();
      check_eq("t2_owner_i", owner_o, 2'b01);
      check_eq("t2_addr_i", mem_addr_o, 32'h200);
      check_eq("t2_rw_i", mem_rw_o, 1'b0);
      check_eq("t2_wdata_i", mem_wdata_o, '0);
      mem_rdata_i = RdPat;
      mem_ready_i = 1'b1;
      #1;
      check_eq("t2_ic_ready", ic_ready_o, 1'b1);
      check_eq("t2_ic_rdata", ic_rdata_o, RdPat);
      check_eq("t2_dc_rdata", dc_rdata_o, '0);
      @(negedge clk_i);
      mem_ready_i    = 1'b0;
      ic_req_valid_i = 1'b0;
      #1;
      check_eq("t2_conflicts", conflict_cnt_o, PerfEn ? 32'd1 : 32'd0);
      check_eq("t2_ic_grants", ic_grant_cnt_o, PerfEn ? 32'd1 : 32'd0);
      check_eq("t2_dc_grants", dc_grant_cnt_o, PerfEn ? 32'd1 : 32'd0);

      // both held continuously: strict D, I alternation
      do_reset();
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h200;
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h300;
      dc_req_rw_i    = 1'b0;
      for (int k = 0; k < 6; k++) begin
         next_cyc();
         check_eq($sformatf("t3_owner_%0d", k), owner_o, (k % 2 == 0) ? 2'b10 : 2'b01);
         mem_ready_i = 1'b1;
         @(negedge clk_i);
         mem_ready_i = 1'b0;
         if (k == 5) begin
            ic_req_valid_i = 1'b0;
            dc_req_valid_i = 1'b0;
         end
         #1;
         check_eq($sformatf("t3_bubble_%0d", k), owner_o, 2'b00);
      end
      check_eq("t3_conflicts", conflict_cnt_o, PerfEn ? 32'd6 : 32'd0);
      check_eq("t3_dc_grants", dc_grant_cnt_o, PerfEn ? 32'd3 : 32'd0);
      check_eq("t3_err", err_o, 1'b0);

      // watchdog: memory never ready, abort after 4 busy cycles
      do_reset();
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h400;
      for (int k = 1; k <= 4; k++) begin
         next_cyc();
         check_eq($sformatf("t4_busy_owner_%0d", k), owner_o, 2'b10);
         check_eq($sformatf("t4_busy_ready_%0d", k), dc_ready_o, 1'b0);
         check_eq($sformatf("t4_busy_err_%0d", k), err_o, 1'b0);
      end
      @(negedge clk_i);
      dc_req_valid_i = 1'b0;
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = 32'h200;
      #1;
      check_eq("t4_timeout_owner", owner_o, 2'b00);
      check_eq("t4_timeout_err", err_o, 1'b1);
      check_eq("t4_timeout_ready", dc_ready_o, 1'b0);
      next_cyc();
      check_eq("t4_ic_owner", owner_o, 2'b01);
      check_eq("t4_ic_addr", mem_addr_o, 32'h200);
      mem_ready_i = 1'b1;
      #1;
      check_eq("t4_ic_ready", ic_ready_o, 1'b1);
      @(negedge clk_i);
      mem_ready_i    = 1'b0;
      ic_req_valid_i = 1'b0;
      #1;
      check_eq("t4_err_sticky", err_o, 1'b1);

      // ready on the timeout cycle wins: no error
      do_reset();
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h440;
      for (int k = 1; k <= 4; k++) next_cyc();
      mem_ready_i = 1'b1;
      #1;
      check_eq("t5_ready_at_limit", dc_ready_o, 1'b1);
      @(negedge clk_i);
      mem_ready_i    = 1'b0;
      dc_req_valid_i = 1'b0;
      #1;
      check_eq("t5_owner", owner_o, 2'b00);
      check_eq("t5_err", err_o, 1'b0);

      // stray ready while idle sets err
      mem_ready_i = 1'b1;
      #1;
      check_eq("t6_idle_ic_ready", ic_ready_o, 1'b0);
      check_eq("t6_idle_dc_ready", dc_ready_o, 1'b0);
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      #1;
      check_eq("t6_idle_err", err_o, 1'b1);

      // dc drops valid 2 cycles into the grant, then reset clears err
      do_reset();
      dc_req_valid_i = 1'b1;
      dc_req_addr_i  = 32'h500;
      next_cyc();
      check_eq("t7_valid", mem_valid_o, 1'b1);
      @(negedge clk_i);
      dc_req_valid_i = 1'b0;
      #1;
      check_eq("t7_drop_valid", mem_valid_o, 1'b0);
      check_eq("t7_drop_owner", owner_o, 2'b10);
      next_cyc();
      check_eq("t7_idle_owner", owner_o, 2'b00);
      check_eq("t7_err", err_o, 1'b1);
      check_eq("t7_dc_grants", dc_grant_cnt_o, PerfEn ? 32'd1 : 32'd0);
      do_reset();
      check_eq("t7_rst_err", err_o, 1'b0);
      check_eq("t7_rst_cnts", {ic_grant_cnt_o, dc_grant_cnt_o, conflict_cnt_o}, '0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
